// File: rtl/ifid_hazard_ctrl.sv
// IF/ID and PC sequencer: branch flush, load-use stall, fetch wait and debug halt,
// with saturating stall/flush performance counters.
module ifid_hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int FLUSH_SLOTS = 1,
  parameter int LU_CYCLES   = 1,
  parameter bit R0_ZERO     = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_tkn,
  input  logic              imem_ready,
  input  logic              halt_req,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // state    | meaning
  // RUN      | normal fetch/decode, events evaluated each cycle
  // FLUSH    | squashing wrong-path fetch slots after a taken branch (cnt left)
  // LU_STALL | holding PC and IF/ID for a multi-cycle load-use hazard (cnt left)
  // HALT     | parked by debug request, released when halt_req drops
  typedef enum logic [1:0] {RUN, FLUSH, LU_STALL, HALT} state_t;

  localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_SLOTS - 1);
  localparam logic [1:0]       LU_LOAD    = 2'(LU_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       lu_hazard;
  logic       flush_inc;
  logic       stall_inc;

  assign lu_hazard = ex_mem_read && ((ex_rd != '0) || !R0_ZERO) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    flush_inc   = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (!rst) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = '0;
    end else if (ex_branch_tkn) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      if (FLUSH_SLOTS > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_LOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else if (state == FLUSH) begin
      pc_en      = imem_ready;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      cnt_nxt    = cnt - 2'd1;
      if (cnt_nxt == '0) state_nxt = RUN;
    end else if (state == HALT) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      halted      = 1'b1;
      if (!halt_req) state_nxt = RUN;
    end else if (lu_hazard || state == LU_STALL) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      if (state == LU_STALL) begin
        cnt_nxt = cnt - 2'd1;
        if (cnt_nxt == '0) state_nxt = RUN;
      end else if (LU_CYCLES > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt   = LU_LOAD;
      end
    end else if (!imem_ready) begin
      // ID keeps draining; the missing fetch becomes a NOP in IF/ID
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end else if (halt_req) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      halted      = 1'b1;
      state_nxt   = HALT;
    end
  end

  assign stall_inc = rst && !pc_en && (state != HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Scoreboard bench: two configurations driven in lockstep, expected outputs and
// counters produced by a cycle model and queued, then popped when the DUTs respond.
module tb_ifid_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_tkn, imem_ready, halt_req;

  logic        a_pc, a_en, a_fl, a_bu, a_ha;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_en, b_fl, b_bu, b_ha;
  logic [3:0]  b_sc, b_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifid_hazard_ctrl #(.REG_AW(3), .FLUSH_SLOTS(2), .LU_CYCLES(2), .R0_ZERO(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_tkn(ex_branch_tkn), .imem_ready(imem_ready), .halt_req(halt_req),
    .pc_en(a_pc), .ifid_en(a_en), .ifid_flush(a_fl), .idex_bubble(a_bu), .halted(a_ha),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  ifid_hazard_ctrl #(.REG_AW(3), .FLUSH_SLOTS(1), .LU_CYCLES(1), .R0_ZERO(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_tkn(ex_branch_tkn), .imem_ready(imem_ready), .halt_req(halt_req),
    .pc_en(b_pc), .ifid_en(b_en), .ifid_flush(b_fl), .idex_bubble(b_bu), .halted(b_ha),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  localparam int S_RUN = 0, S_FL = 1, S_LU = 2, S_HA = 3;

  typedef struct {
    int st;
    int cnt;
    int sc;
    int fc;
  } ms_t;

  typedef struct {
    logic [4:0] oa;
    logic [4:0] ob;
    int sca, fca, scb, fcb;
  } exp_t;

  ms_t  ma, mb;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // outputs packed as {pc_en, ifid_en, ifid_flush, idex_bubble, halted}
  function automatic void mdl(input ms_t s, input int fs, input int luc, input bit r0,
                              input int cw, output logic [4:0] o, output ms_t n);
    bit lu, finc;
    int mx;
    mx = (1 << cw) - 1;
    n = s;
    finc = 0;
    lu = ex_mem_read && (ex_rd != 3'd0 || !r0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst) begin
      o = 5'b01110;
      n = '{S_RUN, 0, 0, 0};
      return;
    end
    if (ex_branch_tkn) begin
      o = 5'b11110; finc = 1;
      n.st = (fs > 1) ? S_FL : S_RUN;
      n.cnt = (fs > 1) ? fs - 1 : 0;
    end else if (s.st == S_FL) begin
      o = {imem_ready, 4'b1100}; finc = 1;
      n.cnt = s.cnt - 1;
      if (n.cnt == 0) n.st = S_RUN;
    end else if (s.st == S_HA) begin
      o = 5'b00011;
      if (!halt_req) n.st = S_RUN;
    end else if (lu || s.st == S_LU) begin
      o = 5'b00010;
      if (s.st == S_LU) begin
        n.cnt = s.cnt - 1;
        if (n.cnt == 0) n.st = S_RUN;
      end else if (luc > 1) begin
        n.st = S_LU; n.cnt = luc - 1;
      end
    end else if (!imem_ready) begin
      o = 5'b01100;
    end else if (halt_req) begin
      o = 5'b00011; n.st = S_HA;
    end else begin
      o = 5'b11000;
    end
    if (!o[4] && s.st != S_HA && n.sc < mx) n.sc++;
    if (finc && n.fc < mx) n.fc++;
  endfunction

  // inputs are set just after a rising edge; outputs checked at the falling edge,
  // registered counters checked just after the next rising edge
  task automatic cycle(input string tag);
    exp_t e, g;
    ms_t na, nb;
    mdl(ma, 2, 2, 1'b1, 16, e.oa, na);
    mdl(mb, 1, 1, 1'b0, 4, e.ob, nb);
    e.sca = na.sc; e.fca = na.fc; e.scb = nb.sc; e.fcb = nb.fc;
    sb.push_back(e);
    ma = na; mb = nb;
    @(negedge clk);
    g = sb.pop_front();
    chk({tag, ".a_out"}, {27'd0, a_pc, a_en, a_fl, a_bu, a_ha}, {27'd0, g.oa});
    chk({tag, ".b_out"}, {27'd0, b_pc, b_en, b_fl, b_bu, b_ha}, {27'd0, g.ob});
    @(posedge clk);
    #1;
    chk({tag, ".a_stall"}, {16'd0, a_sc}, g.sca);
    chk({tag, ".a_flush"}, {16'd0, a_fc}, g.fca);
    chk({tag, ".b_stall"}, {28'd0, b_sc}, g.scb);
    chk({tag, ".b_flush"}, {28'd0, b_fc}, g.fcb);
  endtask

  task automatic idle();
    rst = 1'b1; id_rs1 = 3'd1; id_rs2 = 3'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 3'd5; ex_branch_tkn = 1'b0; imem_ready = 1'b1; halt_req = 1'b0;
  endtask

  initial begin
    ma = '{S_RUN, 0, 0, 0};
    mb = '{S_RUN, 0, 0, 0};
    idle();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cycle("reset");
    rst = 1'b1;
    cycle("release");
    cycle("run");

    // load-use on rs2
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b1;
    cycle("lu_hit");
    idle();
    for (int i = 0; i < 3; i++) cycle("lu_after");

    // load into r0: ignored only when r0 is hardwired
    ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs1 = 3'd0; id_use_rs1 = 1'b1;
    cycle("r0_load");
    idle();
    cycle("r0_after");

    // branch and load-use in the same cycle
    ex_branch_tkn = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b1;
    cycle("br_lu");
    idle();
    for (int i = 0; i < 3; i++) cycle("br_after");

    // fetch wait
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle("imem_wait");
    idle();
    cycle("imem_back");

    // debug halt
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) cycle("halt");
    idle();
    for (int i = 0; i < 2; i++) cycle("unhalt");

    // taken branch on the halt entry cycle
    halt_req = 1'b1; ex_branch_tkn = 1'b1;
    cycle("halt_br");
    ex_branch_tkn = 1'b0;
    for (int i = 0; i < 3; i++) cycle("halt_br_after");
    idle();
    cycle("halt_br_rel");

    // reset mid-FLUSH
    ex_branch_tkn = 1'b1;
    cycle("pre_rst_br");
    idle();
    rst = 1'b0;
    cycle("mid_rst");
    rst = 1'b1;
    cycle("post_rst");

    // counter saturation on the narrow instance
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle("sat_stall");
    idle();
    ex_branch_tkn = 1'b1;
    for (int i = 0; i < 20; i++) cycle("sat_flush");
    idle();
    cycle("sat_idle");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      id_rs1 = 3'($urandom_range(0, 7));
      id_rs2 = 3'($urandom_range(0, 7));
      ex_rd = 3'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_branch_tkn = ($urandom_range(0, 7) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      halt_req = ($urandom_range(0, 9) == 0) ? ~halt_req : halt_req;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
